// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   state_e      : FSM state encoding (also exported on state_o for debug)
//   OP_*         : instruction opcodes (IR[31:26])
//   ALUOP_*      : ALUOp encodings
//   SRCB_*       : ALUSrcB encodings
//   PCSRC_*      : PCSource encodings
//   FAULT_*      : sticky fault report codes
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      StReset  = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StMemAdr = 4'd3,
      StMemRd  = 4'd4,
      StMemWb  = 4'd5,
      StMemWr  = 4'd6,
      StExec   = 4'd7,
      StAluWb  = 4'd8,
      StBranch = 4'd9,
      StJump   = 4'd10,
      StAddiEx = 4'd11,
      StAddiWb = 4'd12,
      StTrap   = 4'd13
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating wait-state counter for memory handshakes.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   clear   : zero the counter (takes priority over tick)
//   tick    : count one not-ready cycle
//   expired : counter has reached MAX_WAIT (never set when MAX_WAIT = 0)
module mc_wait_timer #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   // One extra code above MAX_WAIT so saturation never aliases onto MAX_WAIT.
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 2);

   logic [WAIT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (tick && (r_count != {WAIT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expired = (MAX_WAIT != 0) && (r_count == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing each instruction over 3-5 cycles,
// with memory ready handshake, wait-state timeout and illegal-opcode trap.
//   clk, rst_n    : clock, asynchronous active-low reset
//   opcode        : IR[31:26]
//   mem_ready     : memory completes the current access this cycle
//   PCWrite ... PCSource : datapath control strobes and mux selects
//   state_o       : current state encoding (debug)
//   fault         : sticky fault code (00 none, 01 illegal opcode, 10 memory timeout)
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WAIT    = 15,
   parameter bit          ENABLE_ADDI = 1'b1,
   parameter bit          ENABLE_J    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] state_o,
   output logic [1:0] fault
);

   state_e     r_state, w_state_next;
   logic [1:0] r_fault, w_fault_next;
   logic       w_mem_state, w_tick, w_clear, w_expired;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StReset;
         r_fault <= FAULT_NONE;
      end else begin
         r_state <= w_state_next;
         r_fault <= w_fault_next;
      end
   end

   assign w_mem_state = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
   assign w_tick      = w_mem_state && !mem_ready;
   assign w_clear     = mem_ready || (w_state_next != r_state);

   mc_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_clear),
      .tick    (w_tick),
      .expired (w_expired)
   );

   // Next-state and fault logic
   always_comb begin
      w_state_next = r_state;
      w_fault_next = r_fault;
      unique case (r_state)
         StReset:  w_state_next = StFetch;
         StFetch:  if (mem_ready) w_state_next = StDecode;
         StDecode: begin
            // Unmatched opcodes (including X/Z) fall through to the trap.
            w_state_next = StTrap;
            w_fault_next = FAULT_ILLEGAL;
            case (opcode)
               OP_RTYPE:     begin w_state_next = StExec;   w_fault_next = r_fault; end
               OP_LW, OP_SW: begin w_state_next = StMemAdr; w_fault_next = r_fault; end
               OP_BEQ:       begin w_state_next = StBranch; w_fault_next = r_fault; end
               OP_ADDI: if (ENABLE_ADDI) begin
                  w_state_next = StAddiEx;
                  w_fault_next = r_fault;
               end
               OP_J: if (ENABLE_J) begin
                  w_state_next = StJump;
                  w_fault_next = r_fault;
               end
               default: ;
            endcase
         end
         StMemAdr: w_state_next = (opcode == OP_LW) ? StMemRd : StMemWr;
         StMemRd:  if (mem_ready) w_state_next = StMemWb;
         StMemWr:  if (mem_ready) w_state_next = StFetch;
         StMemWb:  w_state_next = StFetch;
         StExec:   w_state_next = StAluWb;
         StAluWb:  w_state_next = StFetch;
         StBranch: w_state_next = StFetch;
         StJump:   w_state_next = StFetch;
         StAddiEx: w_state_next = StAddiWb;
         StAddiWb: w_state_next = StFetch;
         StTrap:   w_state_next = StTrap;
         default:  w_state_next = StReset;
      endcase
      // A ready on the expiring cycle wins, so only trap while still not ready.
      if (w_tick && w_expired) begin
         w_state_next = StTrap;
         w_fault_next = FAULT_TIMEOUT;
      end
   end

   // Moore output decode (FETCH IRWrite/PCWrite additionally gated by mem_ready)
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RT;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      unique case (r_state)
         StFetch: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         StDecode: ALUSrcB = SRCB_IMM_SH2;
         StMemAdr, StAddiEx: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         StMemRd: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         StMemWb: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         StMemWr: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         StExec: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         StAluWb: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         StBranch: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
         end
         StJump: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         StAddiWb: RegWrite = 1'b1;
         default: ;
      endcase
   end

   assign state_o = r_state;
   assign fault   = r_fault;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus pushes expected {state, controls, fault} per cycle, a negedge
// monitor pops and compares. dut0: MAX_WAIT=4, all ops enabled. dut1: addi/j disabled.
module tb_multicycle_control;

   // State codes in listed order
   localparam logic [3:0] S_RST = 4'd0, S_FET = 4'd1, S_DEC = 4'd2, S_MAD = 4'd3,
                          S_MRD = 4'd4, S_MWB = 4'd5, S_MWR = 4'd6, S_EXE = 4'd7,
                          S_AWB = 4'd8, S_BR  = 4'd9, S_JMP = 4'd10, S_AEX = 4'd11,
                          S_AWB2 = 4'd12, S_TRP = 4'd13;

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
   //  ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
   localparam logic [15:0] C_ZERO = 16'h0000, C_FET1 = 16'h9410, C_FET0 = 16'h1010,
                           C_DEC = 16'h0030, C_MAD = 16'h0060, C_MRD = 16'h3000,
                           C_MWB = 16'h0280, C_MWR = 16'h2800, C_EXE = 16'h0048,
                           C_AWB = 16'h0180, C_BR = 16'h4045, C_JMP = 16'h8002,
                           C_AWB2 = 16'h0080;

   localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                          O_BEQ = 6'b000100, O_ADDI = 6'b001000, O_J = 6'b000010,
                          O_BAD = 6'b111111;

   typedef struct packed {
      logic        sel;
      logic [3:0]  st;
      logic [15:0] ctrl;
      logic [1:0]  flt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;

   logic        pcw [2], pcwc [2], iord [2], mrd [2], mwr [2], irw [2], m2r [2], rdst [2];
   logic        rw [2], srca [2];
   logic [1:0]  srcb [2], aop [2], pcs [2], flt [2];
   logic [3:0]  st [2];

   exp_t q[$];
   exp_t e;
   logic [21:0] act, want;
   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multicycle_control #(
      .MAX_WAIT    (4),
      .ENABLE_ADDI (1'b1),
      .ENABLE_J    (1'b1)
   ) dut0 (
      .clk (clk), .rst_n (rst_n), .opcode (opcode), .mem_ready (mem_ready),
      .PCWrite (pcw[0]), .PCWriteCond (pcwc[0]), .IorD (iord[0]), .MemRead (mrd[0]),
      .MemWrite (mwr[0]), .IRWrite (irw[0]), .MemtoReg (m2r[0]), .RegDst (rdst[0]),
      .RegWrite (rw[0]), .ALUSrcA (srca[0]), .ALUSrcB (srcb[0]), .ALUOp (aop[0]),
      .PCSource (pcs[0]), .state_o (st[0]), .fault (flt[0])
   );

   multicycle_control #(
      .MAX_WAIT    (15),
      .ENABLE_ADDI (1'b0),
      .ENABLE_J    (1'b0)
   ) dut1 (
      .clk (clk), .rst_n (rst_n), .opcode (opcode), .mem_ready (mem_ready),
      .PCWrite (pcw[1]), .PCWriteCond (pcwc[1]), .IorD (iord[1]), .MemRead (mrd[1]),
      .MemWrite (mwr[1]), .IRWrite (irw[1]), .MemtoReg (m2r[1]), .RegDst (rdst[1]),
      .RegWrite (rw[1]), .ALUSrcA (srca[1]), .ALUSrcB (srcb[1]), .ALUOp (aop[1]),
      .PCSource (pcs[1]), .state_o (st[1]), .fault (flt[1])
   );

   // Monitor: one expected entry per cycle, checked mid-cycle
   always @(negedge clk) begin
      if (q.size() != 0) begin
         e = q.pop_front();
         if (e.sel) act = {st[1], pcw[1], pcwc[1], iord[1], mrd[1], mwr[1], irw[1], m2r[1],
                           rdst[1], rw[1], srca[1], srcb[1], aop[1], pcs[1], flt[1]};
         else       act = {st[0], pcw[0], pcwc[0], iord[0], mrd[0], mwr[0], irw[0], m2r[0],
                           rdst[0], rw[0], srca[0], srcb[0], aop[0], pcs[0], flt[0]};
         want = {e.st, e.ctrl, e.flt};
         n_vec++;
         if (act !== want) begin
            n_bad++;
            $display("FAIL vec%0d dut%0d: got state=%0d ctrl=%h fault=%b, want state=%0d ctrl=%h fault=%b",
                     n_vec, e.sel, act[21:18], act[17:2], act[1:0], want[21:18], want[17:2],
                     want[1:0]);
         end
      end
   end

   // Apply inputs for one cycle and queue what the selected DUT must show during it
   task automatic step(input logic r, input logic [5:0] op, input logic rdy, input logic sel,
                       input logic [3:0] s, input logic [15:0] c, input logic [1:0] f);
      exp_t x;
      rst_n     = r;
      opcode    = op;
      mem_ready = rdy;
      x.sel = sel; x.st = s; x.ctrl = c; x.flt = f;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; opcode = O_R; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      // Reset and release
      step(0, O_R, 1, 0, S_RST, C_ZERO, 2'b00);
      step(0, O_R, 1, 0, S_RST, C_ZERO, 2'b00);
      step(1, O_R, 1, 0, S_RST, C_ZERO, 2'b00);
      // R-type: 4 cycles
      step(1, O_R, 1, 0, S_FET, C_FET1, 2'b00);
      step(1, O_R, 1, 0, S_DEC, C_DEC,  2'b00);
      step(1, O_R, 1, 0, S_EXE, C_EXE,  2'b00);
      step(1, O_R, 1, 0, S_AWB, C_AWB,  2'b00);
      // lw with 3 not-ready cycles in MEMRD
      step(1, O_LW, 1, 0, S_FET, C_FET1, 2'b00);
      step(1, O_LW, 1, 0, S_DEC, C_DEC,  2'b00);
      step(1, O_LW, 1, 0, S_MAD, C_MAD,  2'b00);
      for (int i = 0; i < 3; i++) step(1, O_LW, 0, 0, S_MRD, C_MRD, 2'b00);
      step(1, O_LW, 1, 0, S_MRD, C_MRD, 2'b00);
      step(1, O_LW, 1, 0, S_MWB, C_MWB, 2'b00);
      // beq: 3 cycles
      step(1, O_BEQ, 1, 0, S_FET, C_FET1, 2'b00);
      step(1, O_BEQ, 1, 0, S_DEC, C_DEC,  2'b00);
      step(1, O_BEQ, 1, 0, S_BR,  C_BR,   2'b00);
      // j: 3 cycles
      step(1, O_J, 1, 0, S_FET, C_FET1, 2'b00);
      step(1, O_J, 1, 0, S_DEC, C_DEC,  2'b00);
      step(1, O_J, 1, 0, S_JMP, C_JMP,  2'b00);
      // addi: 4 cycles
      step(1, O_ADDI, 1, 0, S_FET,  C_FET1, 2'b00);
      step(1, O_ADDI, 1, 0, S_DEC,  C_DEC,  2'b00);
      step(1, O_ADDI, 1, 0, S_AEX,  C_MAD,  2'b00);
      step(1, O_ADDI, 1, 0, S_AWB2, C_AWB2, 2'b00);
      // sw, reset asserted mid-MEMWR drops MemWrite at once
      step(1, O_SW, 1, 0, S_FET, C_FET1, 2'b00);
      step(1, O_SW, 1, 0, S_DEC, C_DEC,  2'b00);
      step(1, O_SW, 1, 0, S_MAD, C_MAD,  2'b00);
      step(1, O_SW, 0, 0, S_MWR, C_MWR,  2'b00);
      step(0, O_SW, 0, 0, S_RST, C_ZERO, 2'b00);
      step(1, O_SW, 1, 0, S_RST, C_ZERO, 2'b00);
      // sw completing normally: 4 cycles
      step(1, O_SW, 1, 0, S_FET, C_FET1, 2'b00);
      step(1, O_SW, 1, 0, S_DEC, C_DEC,  2'b00);
      step(1, O_SW, 1, 0, S_MAD, C_MAD,  2'b00);
      step(1, O_SW, 1, 0, S_MWR, C_MWR,  2'b00);
      // 4 not-ready FETCH cycles then ready on the expiry cycle: no trap
      for (int i = 0; i < 4; i++) step(1, O_BAD, 0, 0, S_FET, C_FET0, 2'b00);
      step(1, O_BAD, 1, 0, S_FET, C_FET1, 2'b00);
      // Illegal opcode traps, sticky
      step(1, O_BAD, 1, 0, S_DEC, C_DEC,  2'b00);
      step(1, O_BAD, 1, 0, S_TRP, C_ZERO, 2'b01);
      step(1, O_R,   1, 0, S_TRP, C_ZERO, 2'b01);
      step(0, O_R,   1, 0, S_RST, C_ZERO, 2'b00);
      step(1, O_R,   0, 0, S_RST, C_ZERO, 2'b00);
      // Timeout: 5th consecutive not-ready FETCH cycle traps
      for (int i = 0; i < 5; i++) step(1, O_R, 0, 0, S_FET, C_FET0, 2'b00);
      step(1, O_R, 0, 0, S_TRP, C_ZERO, 2'b10);
      step(1, O_R, 1, 0, S_TRP, C_ZERO, 2'b10);
      step(0, O_R, 1, 0, S_RST, C_ZERO, 2'b00);
      // dut1: addi and j disabled -> illegal
      step(1, O_ADDI, 1, 1, S_RST, C_ZERO, 2'b00);
      step(1, O_ADDI, 1, 1, S_FET, C_FET1, 2'b00);
      step(1, O_ADDI, 1, 1, S_DEC, C_DEC,  2'b00);
      step(1, O_ADDI, 1, 1, S_TRP, C_ZERO, 2'b01);
      step(0, O_J,    1, 1, S_RST, C_ZERO, 2'b00);
      step(1, O_J,    1, 1, S_RST, C_ZERO, 2'b00);
      step(1, O_J,    1, 1, S_FET, C_FET1, 2'b00);
      step(1, O_J,    1, 1, S_DEC, C_DEC,  2'b00);
      step(1, O_J,    1, 1, S_TRP, C_ZERO, 2'b01);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
